accum_requant: RTL

Requantization stage directly upstream of the activation unit. Takes raw signed MAC accumulator values and produces saturated signed 16-bit results on a valid/ready stream for the activation unit's `data_in`. Per sample it adds a bias, applies a rounding arithmetic right shift and saturates. It is a 3-stage pipeline with full backpressure and a saturation-event counter.

---
 rtl/accum_requant.sv | 126 ++++++++++++
 1 files changed

// File: rtl/accum_requant.sv
// accum_requant: bias add, rounding arithmetic right shift and signed
// saturation of MAC accumulator values, as a 3-stage valid/ready pipeline
// with a saturation-event counter.
module accum_requant #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic [OUT_W-1:0]   bias,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   data_out,
    output logic               sat_flag,
    output logic [15:0]        sat_count,
    input  logic               clear_stats
);

    localparam int STAGES = 3;
    localparam int SW     = ACC_W + 1;   // S1 sum width
    localparam int RW     = ACC_W + 2;   // S2 rounding/shift width

    // Saturation bounds, sign-extended to the S2 width.
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [RW-1:0]        ONE  = {{(RW-1){1'b0}}, 1'b1};

    logic [STAGES:1]      vld_pipe_q;
    logic                 adv;

    logic [SW-1:0]        sum1_d, sum1_q;
    logic [SHIFT_W-1:0]   sh1_q;
    logic [RW-1:0]        rnd;
    logic signed [RW-1:0] r2;
    logic signed [RW-1:0] q2_d, q2_q;
    logic [OUT_W-1:0]     data_d, data_q;
    logic                 sat_d, sat_q;
    logic [15:0]          cnt_d, cnt_q;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign adv       = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[STAGES];
    assign data_out  = data_q;
    assign sat_flag  = sat_q;
    assign sat_count = cnt_q;

    // Valid bits shift together with the data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_pipe_q <= '0;
        else if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
    end

    // S1: sign-extended bias add; shift travels with the sample.
    assign sum1_d = {acc_in[ACC_W-1], acc_in} + {{(SW-OUT_W){bias[OUT_W-1]}}, bias};

    // S1 register, loaded only on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum1_q <= '0;
            sh1_q  <= '0;
        end else if (adv && in_valid) begin
            sum1_q <= sum1_d;
            sh1_q  <= shift;
        end
    end

    // S2: add half an LSB of the result, then arithmetic shift (round half up).
    always_comb begin
        rnd = '0;
        if (sh1_q != '0) rnd = ONE << (sh1_q - 1'b1);
        r2   = {sum1_q[SW-1], sum1_q} + rnd;
        q2_d = r2 >>> sh1_q;
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      q2_q <= '0;
        else if (adv && vld_pipe_q[1])   q2_q <= q2_d;
    end

    // S3: clip to the signed output range and flag clipping.
    always_comb begin
        data_d = q2_q[OUT_W-1:0];
        sat_d  = 1'b0;
        if (q2_q > MAXV) begin
            data_d = {1'b0, {(OUT_W-1){1'b1}}};
            sat_d  = 1'b1;
        end else if (q2_q < MINV) begin
            data_d = {1'b1, {(OUT_W-1){1'b0}}};
            sat_d  = 1'b1;
        end
    end

    // S3 output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sat_q  <= 1'b0;
        end else if (adv && vld_pipe_q[2]) begin
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    // Clipped-result counter: counts delivered clipped results, sticks at max, clear wins.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_stats)
            cnt_d = '0;
        else if (vld_pipe_q[STAGES] && out_ready && sat_q && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule
